// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, access-size codes
// and the default memory-timeout depth.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  // funct3[1:0] selects the access size, funct3[2] marks an unsigned load
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;
  localparam int         F3_UNSIGNED_BIT = 2;
  localparam logic [2:0] F3_LOAD_ILLEGAL = 3'b111;

  localparam int MEM_TIMEOUT_DEF = 255;

  function automatic logic [7:0] size_lanes(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_lanes = 8'h01;
      SZ_H:    size_lanes = 8'h03;
      SZ_W:    size_lanes = 8'h0F;
      default: size_lanes = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane alignment: store data shift, write strobes,
// misalignment detection and load extract/extend.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  req_off,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_wdata,
  output logic [63:0] st_wdata,
  output logic [7:0]  strb,
  output logic        misalign,
  input  logic [2:0]  ld_off,
  input  logic [2:0]  ld_funct3,
  input  logic [63:0] ld_rdata,
  output logic [63:0] ld_data
);

  logic [63:0] ld_sh;
  logic        ld_uns;

  always_comb begin
    st_wdata = req_wdata << {req_off, 3'b000};
    strb     = size_lanes(req_funct3[1:0]) << req_off;

    case (req_funct3[1:0])
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = req_off[0];
      SZ_W:    misalign = |req_off[1:0];
      default: misalign = |req_off;
    endcase

    ld_sh  = ld_rdata >> {ld_off, 3'b000};
    ld_uns = ld_funct3[F3_UNSIGNED_BIT];
    case (ld_funct3[1:0])
      SZ_B:    ld_data = ld_uns ? {56'd0, ld_sh[7:0]}  : 64'($signed(ld_sh[7:0]));
      SZ_H:    ld_data = ld_uns ? {48'd0, ld_sh[15:0]} : 64'($signed(ld_sh[15:0]));
      SZ_W:    ld_data = ld_uns ? {32'd0, ld_sh[31:0]} : 64'($signed(ld_sh[31:0]));
      default: ld_data = ld_sh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core access at a time, issues a single aligned
// memory transaction, and returns the extended load result for one DONE cycle.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ren,
  input  logic        i_wen,
  input  logic [63:0] i_addr,
  input  logic [63:0] i_wdata,
  input  logic [2:0]  i_funct3,
  output logic [63:0] o_rdata,
  output logic        o_stall,
  output logic        o_fault,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [63:0] o_mem_addr,
  output logic [63:0] o_mem_wdata,
  output logic [7:0]  o_mem_wstrb,
  input  logic        i_mem_ack,
  input  logic [63:0] i_mem_rdata
);

  localparam int               CNT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(MEM_TIMEOUT);

  lsu_state_e       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             fault_q;
  logic [63:0]      rdata_q;
  logic [2:0]       funct3_q;
  logic [2:0]       off_q;

  logic [63:0] st_wdata;
  logic [7:0]  strb;
  logic        misalign;
  logic [63:0] ld_data;
  logic        req_any, req_bad, timeout_hit;

  lsu_align u_align (
    .req_off    (i_addr[2:0]),
    .req_funct3 (i_funct3),
    .req_wdata  (i_wdata),
    .st_wdata   (st_wdata),
    .strb       (strb),
    .misalign   (misalign),
    .ld_off     (off_q),
    .ld_funct3  (funct3_q),
    .ld_rdata   (i_mem_rdata),
    .ld_data    (ld_data)
  );

  always_comb begin
    req_any     = i_ren | i_wen;
    req_bad     = (i_ren & i_wen)
                | (i_ren & (i_funct3 == F3_LOAD_ILLEGAL))
                | (i_wen & i_funct3[F3_UNSIGNED_BIT])
                | misalign;
    cnt_inc     = cnt_q + CNT_W'(1);
    timeout_hit = 1'b0;
    state_nxt   = state_q;
    o_stall     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          o_stall   = 1'b1;
          state_nxt = req_bad ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        o_stall = 1'b1;
        if (i_mem_ack) begin
          state_nxt = ST_DONE;
        end else if (cnt_inc == TO_VAL) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    if (i_rst) o_stall = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fault_q     <= 1'b0;
      rdata_q     <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= '0;
    end else begin
      state_q <= state_nxt;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (req_any) begin
            // invalid requests still latch fields but never reach memory
            fault_q     <= req_bad;
            o_mem_req   <= ~req_bad;
            o_mem_we    <= i_wen;
            o_mem_addr  <= {i_addr[63:3], 3'b000};
            o_mem_wdata <= st_wdata;
            o_mem_wstrb <= strb;
            funct3_q    <= i_funct3;
            off_q       <= i_addr[2:0];
            rdata_q     <= '0;
          end
        end
        ST_WAIT: begin
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            rdata_q   <= o_mem_we ? '0 : ld_data;
          end else if (timeout_hit) begin
            o_mem_req <= 1'b0;
            fault_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rdata = (state_q == ST_DONE && !fault_q) ? rdata_q : '0;
  assign o_fault = (state_q == ST_DONE) & fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of single transactions plus
// hand-written timeout, stray-ack and reset-in-WAIT sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        i_rst, i_ren, i_wen, i_mem_ack;
  logic [63:0] i_addr, i_wdata, i_mem_rdata;
  logic [2:0]  i_funct3;
  logic [63:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic        o_stall, o_fault, o_mem_req, o_mem_we;
  logic [7:0]  o_mem_wstrb;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_TIMEOUT(4)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_ren       (i_ren),
    .i_wen       (i_wen),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_funct3    (i_funct3),
    .o_rdata     (o_rdata),
    .o_stall     (o_stall),
    .o_fault     (o_fault),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_wstrb (o_mem_wstrb),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata)
  );

  typedef struct {
    logic        ren;
    logic        wen;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          dly;
    logic        flt;
    logic [63:0] exp_rdata;
    logic [63:0] exp_addr;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_strb;
  } vec_t;

  vec_t vt[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_ren = 1'b0; i_wen = 1'b0; i_mem_ack = 1'b0;
    i_addr = '0; i_wdata = '0; i_funct3 = '0; i_mem_rdata = '0;
  endtask

  initial begin
    vt.push_back(vec_t'{1, 0, 3'b010, 64'h1004, 64'h0, 64'h8000_0001_0000_0000, 2, 0,
                        64'hFFFF_FFFF_8000_0001, 64'h1000, 64'h0, 8'h00});
    vt.push_back(vec_t'{0, 1, 3'b000, 64'h2003, 64'hAB, 64'h0, 1, 0,
                        64'h0, 64'h2000, 64'h0000_0000_AB00_0000, 8'h08});
    vt.push_back(vec_t'{1, 0, 3'b101, 64'h3006, 64'h0, 64'hBEEF_0000_0000_0000, 1, 0,
                        64'h0000_0000_0000_BEEF, 64'h3000, 64'h0, 8'h00});
    vt.push_back(vec_t'{1, 0, 3'b011, 64'h4004, 64'h0, 64'h0, 0, 1,
                        64'h0, 64'h0, 64'h0, 8'h00});
    vt.push_back(vec_t'{1, 0, 3'b000, 64'h5001, 64'h0, 64'h0000_0000_0000_8000, 1, 0,
                        64'hFFFF_FFFF_FFFF_FF80, 64'h5000, 64'h0, 8'h00});
    vt.push_back(vec_t'{1, 0, 3'b100, 64'h5001, 64'h0, 64'h0000_0000_0000_8000, 3, 0,
                        64'h0000_0000_0000_0080, 64'h5000, 64'h0, 8'h00});
    vt.push_back(vec_t'{0, 1, 3'b011, 64'h6000, 64'h1122_3344_5566_7788, 64'h0, 3, 0,
                        64'h0, 64'h6000, 64'h1122_3344_5566_7788, 8'hFF});
    vt.push_back(vec_t'{0, 1, 3'b001, 64'h6002, 64'hFFFF_FFFF_FFFF_1234, 64'h0, 1, 0,
                        64'h0, 64'h6000, 64'hFFFF_FFFF_1234_0000, 8'h0C});
    vt.push_back(vec_t'{0, 1, 3'b010, 64'h600C, 64'hDEAD_BEEF, 64'h0, 2, 0,
                        64'h0, 64'h6008, 64'hDEAD_BEEF_0000_0000, 8'hF0});
    vt.push_back(vec_t'{1, 0, 3'b110, 64'h7004, 64'h0, 64'h8000_0001_0000_0000, 1, 0,
                        64'h0000_0000_8000_0001, 64'h7000, 64'h0, 8'h00});
    vt.push_back(vec_t'{1, 0, 3'b001, 64'h7002, 64'h0, 64'h0000_0000_F00D_0000, 2, 0,
                        64'hFFFF_FFFF_FFFF_F00D, 64'h7000, 64'h0, 8'h00});
    vt.push_back(vec_t'{1, 0, 3'b011, 64'hA008, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 0,
                        64'h0123_4567_89AB_CDEF, 64'hA008, 64'h0, 8'h00});
    vt.push_back(vec_t'{1, 1, 3'b011, 64'h8000, 64'h0, 64'h0, 0, 1,
                        64'h0, 64'h0, 64'h0, 8'h00});
    vt.push_back(vec_t'{1, 0, 3'b111, 64'h8000, 64'h0, 64'h0, 0, 1,
                        64'h0, 64'h0, 64'h0, 8'h00});
    vt.push_back(vec_t'{0, 1, 3'b100, 64'h8000, 64'h0, 64'h0, 0, 1,
                        64'h0, 64'h0, 64'h0, 8'h00});
    vt.push_back(vec_t'{1, 0, 3'b001, 64'h9001, 64'h0, 64'h0, 0, 1,
                        64'h0, 64'h0, 64'h0, 8'h00});
    vt.push_back(vec_t'{0, 1, 3'b010, 64'h9002, 64'h0, 64'h0, 0, 1,
                        64'h0, 64'h0, 64'h0, 8'h00});

    // reset with a request pending: nothing may leave the unit
    idle_inputs();
    i_rst = 1'b1; i_ren = 1'b1; i_funct3 = 3'b011;
    adv(); adv();
    smp();
    chk("rst_stall", 64'(o_stall), 64'd0);
    chk("rst_mem_req", 64'(o_mem_req), 64'd0);
    chk("rst_mem_we", 64'(o_mem_we), 64'd0);
    chk("rst_wstrb", 64'(o_mem_wstrb), 64'd0);
    chk("rst_fault", 64'(o_fault), 64'd0);
    chk("rst_rdata", o_rdata, 64'd0);
    adv();
    idle_inputs();
    i_rst = 1'b0;
    adv();

    for (int i = 0; i < vt.size(); i++) begin
      i_ren = vt[i].ren; i_wen = vt[i].wen; i_funct3 = vt[i].f3;
      i_addr = vt[i].addr; i_wdata = vt[i].wdata; i_mem_ack = 1'b0;
      smp();
      chk($sformatf("v%0d_stall_req", i), 64'(o_stall), 64'd1);
      adv();
      if (!vt[i].flt) begin
        for (int k = 1; k <= vt[i].dly; k++) begin
          if (k == vt[i].dly) begin
            i_mem_ack = 1'b1; i_mem_rdata = vt[i].rdata;
          end
          smp();
          chk($sformatf("v%0d_w%0d_stall", i, k), 64'(o_stall), 64'd1);
          chk($sformatf("v%0d_w%0d_req", i, k), 64'(o_mem_req), 64'd1);
          chk($sformatf("v%0d_w%0d_addr", i, k), o_mem_addr, vt[i].exp_addr);
          chk($sformatf("v%0d_w%0d_we", i, k), 64'(o_mem_we), 64'(vt[i].wen));
          if (vt[i].wen) begin
            chk($sformatf("v%0d_w%0d_wstrb", i, k), 64'(o_mem_wstrb), 64'(vt[i].exp_strb));
            chk($sformatf("v%0d_w%0d_wdata", i, k), o_mem_wdata, vt[i].exp_wdata);
          end
          adv();
        end
      end
      // DONE: a stray ack here must be ignored
      i_mem_ack = 1'b1; i_mem_rdata = '1;
      smp();
      chk($sformatf("v%0d_done_stall", i), 64'(o_stall), 64'd0);
      chk($sformatf("v%0d_done_fault", i), 64'(o_fault), 64'(vt[i].flt));
      chk($sformatf("v%0d_done_rdata", i), o_rdata, vt[i].exp_rdata);
      chk($sformatf("v%0d_done_req", i), 64'(o_mem_req), 64'd0);
      adv();
      idle_inputs();
      smp();
      chk($sformatf("v%0d_idle_stall", i), 64'(o_stall), 64'd0);
      chk($sformatf("v%0d_idle_fault", i), 64'(o_fault), 64'd0);
      chk($sformatf("v%0d_idle_rdata", i), o_rdata, 64'd0);
      chk($sformatf("v%0d_idle_req", i), 64'(o_mem_req), 64'd0);
      adv();
    end

    // ack while idle is ignored
    i_mem_ack = 1'b1; i_mem_rdata = 64'h1234_5678_9ABC_DEF0;
    smp();
    chk("idle_ack_stall", 64'(o_stall), 64'd0);
    adv();
    idle_inputs();
    smp();
    chk("idle_ack_rdata", o_rdata, 64'd0);
    chk("idle_ack_req", 64'(o_mem_req), 64'd0);
    chk("idle_ack_fault", 64'(o_fault), 64'd0);
    adv();

    // timeout: four WAIT cycles without ack, then a faulted DONE
    i_ren = 1'b1; i_funct3 = 3'b011; i_addr = 64'hB000;
    smp();
    chk("to_stall_req", 64'(o_stall), 64'd1);
    adv();
    i_ren = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      smp();
      chk($sformatf("to_w%0d_req", k), 64'(o_mem_req), 64'd1);
      chk($sformatf("to_w%0d_stall", k), 64'(o_stall), 64'd1);
      adv();
    end
    smp();
    chk("to_done_req", 64'(o_mem_req), 64'd0);
    chk("to_done_fault", 64'(o_fault), 64'd1);
    chk("to_done_rdata", o_rdata, 64'd0);
    chk("to_done_stall", 64'(o_stall), 64'd0);
    adv();
    i_mem_ack = 1'b1; i_mem_rdata = '1;
    smp();
    chk("to_late_stall", 64'(o_stall), 64'd0);
    chk("to_late_fault", 64'(o_fault), 64'd0);
    adv();
    idle_inputs();
    smp();
    chk("to_late_rdata", o_rdata, 64'd0);
    chk("to_late_req", 64'(o_mem_req), 64'd0);
    adv();

    // reset asserted while waiting; an ack during reset is dropped
    i_ren = 1'b1; i_funct3 = 3'b010; i_addr = 64'hC000;
    adv();
    i_ren = 1'b0;
    i_rst = 1'b1;
    smp();
    chk("rw_wait_req", 64'(o_mem_req), 64'd1);
    chk("rw_wait_stall", 64'(o_stall), 64'd0);
    adv();
    i_mem_ack = 1'b1; i_mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    smp();
    chk("rw_next_req", 64'(o_mem_req), 64'd0);
    chk("rw_next_stall", 64'(o_stall), 64'd0);
    chk("rw_next_rdata", o_rdata, 64'd0);
    adv();
    i_rst = 1'b0;
    smp();
    chk("rw_rel_rdata", o_rdata, 64'd0);
    chk("rw_rel_fault", 64'(o_fault), 64'd0);
    chk("rw_rel_req", 64'(o_mem_req), 64'd0);
    adv();
    idle_inputs();
    smp();
    chk("rw_after_rdata", o_rdata, 64'd0);
    chk("rw_after_fault", 64'(o_fault), 64'd0);
    chk("rw_after_stall", 64'(o_stall), 64'd0);
    adv();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
